// File: rtl/uni_bus_arbiter_if.sv
// Request/response bundle for a uni-interface port: used both between the caches
// and the arbiter and between the arbiter and the uni->AXI bridge.
interface uni_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
);
    logic                  valid;
    logic                  reqtyp;
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            size;
    logic                  cachable;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ready;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output valid, reqtyp, addr, size, cachable, wdata,
        input  ready, rdata
    );

    modport slave (
        input  valid, reqtyp, addr, size, cachable, wdata,
        output ready, rdata
    );
endinterface

// File: rtl/uni_bus_arbiter.sv
// 2:1 arbiter sharing the uni->AXI bridge between the I-cache (req0) and the
// D-cache/LSU (req1); one outstanding request, fields frozen until bridge ready.
module uni_bus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128,
    parameter int RR_EN      = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    uni_bus_arbiter_if.slave    req0,
    uni_bus_arbiter_if.slave    req1,
    uni_bus_arbiter_if.master   m
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic                  grant_r;
    logic                  last_grant_r;
    logic                  winner_s;
    logic                  any_valid_s;
    logic                  busy_s;

    logic                  sel_reqtyp_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [1:0]            sel_size_s;
    logic                  sel_cachable_s;
    logic [DATA_WIDTH-1:0] sel_wdata_s;

    logic                  m_reqtyp_r;
    logic [ADDR_WIDTH-1:0] m_addr_r;
    logic [1:0]            m_size_r;
    logic                  m_cachable_r;
    logic [DATA_WIDTH-1:0] m_wdata_r;

    // Winner selection, field mux and next-state logic
    always_comb begin
        any_valid_s    = req0.valid | req1.valid;
        winner_s       = 1'b0;
        state_s        = state_r;
        sel_reqtyp_s   = req0.reqtyp;
        sel_addr_s     = req0.addr;
        sel_size_s     = req0.size;
        sel_cachable_s = req0.cachable;
        sel_wdata_s    = req0.wdata;

        // Contention: round-robin flips away from the last winner, fixed favours the D-side
        if (req0.valid && req1.valid) begin
            if (RR_EN != 0) begin
                winner_s = ~last_grant_r;
            end else begin
                winner_s = 1'b1;
            end
        end else if (req1.valid) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end

        if (winner_s) begin
            sel_reqtyp_s   = req1.reqtyp;
            sel_addr_s     = req1.addr;
            sel_size_s     = req1.size;
            sel_cachable_s = req1.cachable;
            sel_wdata_s    = req1.wdata;
        end else begin
            sel_reqtyp_s   = req0.reqtyp;
            sel_addr_s     = req0.addr;
            sel_size_s     = req0.size;
            sel_cachable_s = req0.cachable;
            sel_wdata_s    = req0.wdata;
        end

        case (state_r)
            IDLE: begin
                if (any_valid_s) begin
                    state_s = BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (m.ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = BUSY;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Capture the winner's request when leaving IDLE; held stable through BUSY
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            grant_r      <= 1'b0;
            last_grant_r <= 1'b0;
            m_reqtyp_r   <= 1'b0;
            m_addr_r     <= {ADDR_WIDTH{1'b0}};
            m_size_r     <= 2'b00;
            m_cachable_r <= 1'b0;
            m_wdata_r    <= {DATA_WIDTH{1'b0}};
        end else if ((state_r == IDLE) && any_valid_s) begin
            grant_r      <= winner_s;
            last_grant_r <= winner_s;
            m_reqtyp_r   <= sel_reqtyp_s;
            m_addr_r     <= sel_addr_s;
            m_size_r     <= sel_size_s;
            m_cachable_r <= sel_cachable_s;
            m_wdata_r    <= sel_wdata_s;
        end
    end

    // Valid is gated by ready so the bridge never sees a request in its completion cycle
    always_comb begin
        busy_s     = (state_r == BUSY);
        m.valid    = busy_s & ~m.ready;
        req0.ready = busy_s & m.ready & ~grant_r;
        req1.ready = busy_s & m.ready & grant_r;
    end

    assign m.reqtyp   = m_reqtyp_r;
    assign m.addr     = m_addr_r;
    assign m.size     = m_size_r;
    assign m.cachable = m_cachable_r;
    assign m.wdata    = m_wdata_r;
    assign req0.rdata = m.rdata;
    assign req1.rdata = m.rdata;

endmodule

// File: tb/tb_uni_bus_arbiter.sv
// Directed bench: environment 0 runs the round-robin arbiter, environment 1 the
// fixed-priority one; both share clock and reset.
module tb_uni_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 128;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Stimulus and observation arrays, indexed [env][port]
    logic          rq_valid [2][2];
    logic          rq_typ   [2][2];
    logic [AW-1:0] rq_addr  [2][2];
    logic [1:0]    rq_size  [2][2];
    logic          rq_cach  [2][2];
    logic [DW-1:0] rq_wdata [2][2];
    logic          rq_ready [2][2];
    logic [DW-1:0] rq_rdata [2][2];
    logic          m_ready_v [2];
    logic [DW-1:0] m_rdata_v [2];
    logic          mv     [2];
    logic          mtyp   [2];
    logic [AW-1:0] maddr  [2];
    logic [1:0]    msize  [2];
    logic          mcach  [2];
    logic [DW-1:0] mwdata [2];

    int checks = 0;
    int fails  = 0;
    int proto_errs = 0;

    for (genvar e = 0; e < 2; e++) begin : g_env
        uni_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) r0 ();
        uni_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) r1 ();
        uni_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mb ();

        assign r0.valid    = rq_valid[e][0];
        assign r0.reqtyp   = rq_typ[e][0];
        assign r0.addr     = rq_addr[e][0];
        assign r0.size     = rq_size[e][0];
        assign r0.cachable = rq_cach[e][0];
        assign r0.wdata    = rq_wdata[e][0];
        assign r1.valid    = rq_valid[e][1];
        assign r1.reqtyp   = rq_typ[e][1];
        assign r1.addr     = rq_addr[e][1];
        assign r1.size     = rq_size[e][1];
        assign r1.cachable = rq_cach[e][1];
        assign r1.wdata    = rq_wdata[e][1];
        assign rq_ready[e][0] = r0.ready;
        assign rq_ready[e][1] = r1.ready;
        assign rq_rdata[e][0] = r0.rdata;
        assign rq_rdata[e][1] = r1.rdata;
        assign mb.ready = m_ready_v[e];
        assign mb.rdata = m_rdata_v[e];
        assign mv[e]     = mb.valid;
        assign mtyp[e]   = mb.reqtyp;
        assign maddr[e]  = mb.addr;
        assign msize[e]  = mb.size;
        assign mcach[e]  = mb.cachable;
        assign mwdata[e] = mb.wdata;

        uni_bus_arbiter #(
            .ADDR_WIDTH(AW),
            .DATA_WIDTH(DW),
            .RR_EN     ((e == 0) ? 1 : 0)
        ) dut (
            .i_clk  (clk),
            .i_rst_n(rst_n),
            .req0   (r0),
            .req1   (r1),
            .m      (mb)
        );
    end

    // Requesters must not drop valid while the arbiter is mid-transfer
    logic valid_q [2][2];
    always @(posedge clk) begin
        for (int e = 0; e < 2; e++) begin
            for (int p = 0; p < 2; p++) begin
                if (!rst_n) begin
                    valid_q[e][p] <= 1'b0;
                end else begin
                    if (valid_q[e][p] && !rq_valid[e][p] && mv[e]) begin
                        $display("FAIL protocol: env%0d port%0d dropped valid during BUSY", e, p);
                        proto_errs <= proto_errs + 1;
                    end
                    valid_q[e][p] <= rq_valid[e][p];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] addr_of(input int p, input int idx);
        return (p == 0) ? (32'h8000_0000 + 32'(idx * 16)) : (32'h4000_0000 + 32'(idx * 16));
    endfunction

    // One arbitrated transaction: raise the requests in mask, expect port exp_p to win
    task automatic run_txn(input int e, input logic [1:0] mask, input int exp_p, input int idx);
        int n;
        logic [DW-1:0] rd;
        rd = {4{32'hC0DE_0000 + 32'(idx)}};
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            rq_addr[e][p]  = addr_of(p, idx);
            rq_typ[e][p]   = 1'b0;
            rq_size[e][p]  = 2'd2;
            rq_cach[e][p]  = 1'b1;
            rq_valid[e][p] = mask[p];
        end
        n = 0;
        do begin
            tick();
            n++;
        end while (!mv[e] && n < 8);
        chk($sformatf("txn%0d_m_valid", idx), 128'(mv[e]), 128'd1);
        chk($sformatf("txn%0d_grant_addr", idx), 128'(maddr[e]), 128'(addr_of(exp_p, idx)));
        tick();
        chk($sformatf("txn%0d_no_early_ready", idx), 128'({rq_ready[e][1], rq_ready[e][0]}), 128'd0);
        @(negedge clk);
        m_ready_v[e] = 1'b1;
        m_rdata_v[e] = rd;
        #1;
        chk($sformatf("txn%0d_ready_winner", idx), 128'(rq_ready[e][exp_p]), 128'd1);
        chk($sformatf("txn%0d_ready_loser", idx), 128'(rq_ready[e][1-exp_p]), 128'd0);
        chk($sformatf("txn%0d_rdata", idx), 128'(rq_rdata[e][exp_p]), 128'(rd));
        chk($sformatf("txn%0d_valid_gated", idx), 128'(mv[e]), 128'd0);
        tick();
        m_ready_v[e] = 1'b0;
        rq_valid[e][0] = 1'b0;
        rq_valid[e][1] = 1'b0;
    endtask

    typedef struct {
        int         env;
        logic [1:0] mask;
        int         exp_port;
    } vec_t;

    vec_t tbl [12];

    initial begin
        // env0 round-robin (last_grant=0 after the single read), env1 fixed priority
        tbl[0]  = '{0, 2'b11, 1};
        tbl[1]  = '{0, 2'b11, 0};
        tbl[2]  = '{0, 2'b11, 1};
        tbl[3]  = '{0, 2'b11, 0};
        tbl[4]  = '{0, 2'b10, 1};
        tbl[5]  = '{0, 2'b11, 0};
        tbl[6]  = '{1, 2'b11, 1};
        tbl[7]  = '{1, 2'b11, 1};
        tbl[8]  = '{1, 2'b11, 1};
        tbl[9]  = '{1, 2'b11, 1};
        tbl[10] = '{1, 2'b01, 0};
        tbl[11] = '{1, 2'b10, 1};

        rst_n = 1'b0;
        for (int e = 0; e < 2; e++) begin
            m_ready_v[e] = 1'b0;
            m_rdata_v[e] = '0;
            for (int p = 0; p < 2; p++) begin
                rq_valid[e][p] = 1'b0;
                rq_typ[e][p]   = 1'b0;
                rq_addr[e][p]  = '0;
                rq_size[e][p]  = 2'd0;
                rq_cach[e][p]  = 1'b0;
                rq_wdata[e][p] = '0;
            end
        end
        #12;
        for (int e = 0; e < 2; e++) begin
            chk($sformatf("rst_env%0d_m_valid", e), 128'(mv[e]), 128'd0);
            chk($sformatf("rst_env%0d_fields", e),
                128'({mtyp[e], maddr[e], msize[e], mcach[e]}), 128'd0);
            chk($sformatf("rst_env%0d_wdata", e), 128'(mwdata[e]), 128'd0);
            chk($sformatf("rst_env%0d_ready", e), 128'({rq_ready[e][1], rq_ready[e][0]}), 128'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single cached read on port 0 with exact one-cycle latency
        @(negedge clk);
        rq_valid[0][0] = 1'b1;
        rq_addr[0][0]  = 32'h8000_0000;
        rq_cach[0][0]  = 1'b1;
        rq_size[0][0]  = 2'd2;
        #1;
        chk("t1_valid_before_edge", 128'(mv[0]), 128'd0);
        tick();
        chk("t1_valid_plus1", 128'(mv[0]), 128'd1);
        chk("t1_addr", 128'(maddr[0]), 128'h8000_0000);
        chk("t1_cachable", 128'(mcach[0]), 128'd1);
        tick();
        @(negedge clk);
        m_ready_v[0] = 1'b1;
        m_rdata_v[0] = {16{8'hA5}};
        #1;
        chk("t1_ready0", 128'(rq_ready[0][0]), 128'd1);
        chk("t1_ready1", 128'(rq_ready[0][1]), 128'd0);
        chk("t1_rdata", 128'(rq_rdata[0][0]), {16{8'hA5}});
        tick();
        m_ready_v[0] = 1'b0;
        rq_valid[0][0] = 1'b0;
        chk("t1_ready0_one_cycle", 128'(rq_ready[0][0]), 128'd0);

        for (int i = 0; i < 12; i++) begin
            run_txn(tbl[i].env, tbl[i].mask, tbl[i].exp_port, i);
        end

        // Uncached write on the fixed-priority arbiter, with port 0 arriving mid-transfer
        @(negedge clk);
        rq_valid[1][1] = 1'b1;
        rq_typ[1][1]   = 1'b1;
        rq_size[1][1]  = 2'd0;
        rq_addr[1][1]  = 32'h1000_0003;
        rq_cach[1][1]  = 1'b0;
        rq_wdata[1][1] = 128'h41;
        tick();
        chk("t4_valid", 128'(mv[1]), 128'd1);
        @(negedge clk);
        rq_valid[1][0] = 1'b1;
        rq_typ[1][0]   = 1'b0;
        rq_addr[1][0]  = 32'h2222_0000;
        rq_size[1][0]  = 2'd2;
        rq_cach[1][0]  = 1'b1;
        rq_wdata[1][0] = 128'hFFFF;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("t4_hold%0d", k), 128'({mv[1], mtyp[1], maddr[1], msize[1], mcach[1]}),
                128'({1'b1, 1'b1, 32'h1000_0003, 2'd0, 1'b0}));
            chk($sformatf("t4_wdata%0d", k), 128'(mwdata[1]), 128'h41);
        end
        @(negedge clk);
        m_ready_v[1] = 1'b1;
        #1;
        chk("t4_valid_in_ready", 128'(mv[1]), 128'd0);
        chk("t4_addr_in_ready", 128'(maddr[1]), 128'h1000_0003);
        chk("t4_ready", 128'({rq_ready[1][1], rq_ready[1][0]}), 128'b10);
        tick();
        m_ready_v[1] = 1'b0;
        rq_valid[1][1] = 1'b0;
        tick();
        chk("t4_waiter_granted", 128'({mv[1], maddr[1]}), 128'({1'b1, 32'h2222_0000}));
        @(negedge clk);
        m_ready_v[1] = 1'b1;
        #1;
        chk("t4_waiter_ready", 128'({rq_ready[1][1], rq_ready[1][0]}), 128'b01);
        tick();
        m_ready_v[1] = 1'b0;
        rq_valid[1][0] = 1'b0;

        // Spurious bridge ready while idle
        tick();
        @(negedge clk);
        m_ready_v[0] = 1'b1;
        #1;
        chk("t5_no_ready", 128'({rq_ready[0][1], rq_ready[0][0]}), 128'd0);
        tick();
        m_ready_v[0] = 1'b0;
        chk("t5_stays_idle", 128'(mv[0]), 128'd0);
        tick();
        chk("t5_stays_idle2", 128'(mv[0]), 128'd0);

        // Reset asserted in the middle of a transfer
        @(negedge clk);
        rq_valid[0][0] = 1'b1;
        rq_addr[0][0]  = 32'h3333_0000;
        tick();
        chk("t6_busy", 128'(mv[0]), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 128'(mv[0]), 128'd0);
        chk("t6_async_addr", 128'(maddr[0]), 128'd0);
        rq_valid[0][0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(0, 2'b01, 0, 20);

        chk("protocol_valid_drop", 128'(proto_errs), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
